// File: rtl/conv1_spike_pingpong_buf.sv
// Two-bank ping-pong spike RAM between conv1 and the next conv layer.
// Optional: define CONV1_BUF_STAT_EN to add the saturating spike_total counter port.
module conv1_spike_pingpong_buf #(
  parameter int unsigned           IDX_W     = 16,
  parameter int unsigned           ADDR_W    = 9,
  parameter int unsigned           DEPTH     = 512,
  parameter int unsigned           AF_MARGIN = 4,
  parameter logic [IDX_W-1:0]      EOT_MARK  = 16'hFAF1,
  parameter logic [IDX_W-1:0]      EOF_MARK  = 16'hF1FA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              w_en,
  input  logic [IDX_W-1:0]  s_index_i,
  output logic              almost_full,
  output logic              full,
  output logic [ADDR_W-1:0] addr_most,
  output logic              spike_valid,
  input  logic [ADDR_W-1:0] addr_r_spike,
  output logic [IDX_W-1:0]  s_index_ram,
  input  logic              conv_over,
  output logic              frame_last,
`ifdef CONV1_BUF_STAT_EN
  output logic [31:0]       spike_total,
`endif
  output logic              overflow
);

  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY, B_BUSY} bank_st_t;
  typedef enum logic {RD_IDLE, RD_SERVE} rd_st_t;

  // wr_cnt never holds DEPTH itself: the bank closes on the write that would reach it.
  // When DEPTH == 2**ADDR_W a completely full bank reports addr_most as 0 (wraps).
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AF_TH    = ADDR_W'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(DEPTH);

  logic [IDX_W-1:0]  mem [2][2**ADDR_W];
  bank_st_t          bank_st  [2];
  logic [ADDR_W-1:0] bank_cnt [2];
  logic [1:0]        bank_eof;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  rd_st_t            rd_st;

  logic is_marker;
  logic accept_word;

  assign is_marker   = (s_index_i == EOT_MARK) || (s_index_i == EOF_MARK);
  assign full        = (bank_st[wr_bank] == B_READY) || (bank_st[wr_bank] == B_BUSY);
  assign almost_full = full || (wr_cnt >= AF_TH);
  assign accept_word = w_en && !full && !is_marker;

  always_ff @(posedge clk) begin
    if (accept_word) begin
      mem[wr_bank][wr_cnt] <= s_index_i;
    end
  end

  // Bank states are shared by both sides; the write side only ever touches a FREE/FILL
  // bank and the read side only a READY/BUSY one, so both may act in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0]  <= B_FREE;
      bank_st[1]  <= B_FREE;
      bank_cnt[0] <= '0;
      bank_cnt[1] <= '0;
      bank_eof    <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      overflow    <= 1'b0;
      rd_st       <= RD_IDLE;
      spike_valid <= 1'b0;
      addr_most   <= '0;
      frame_last  <= 1'b0;
      s_index_ram <= '0;
    end else begin
      if (w_en) begin
        if (full) begin
          overflow <= 1'b1;
        end else if (is_marker) begin
          if (wr_cnt != '0) begin
            bank_st[wr_bank]  <= B_READY;
            bank_cnt[wr_bank] <= wr_cnt;
            bank_eof[wr_bank] <= (s_index_i == EOF_MARK);
            wr_bank           <= ~wr_bank;
            wr_cnt            <= '0;
          end
        end else if (wr_cnt == LAST_IDX) begin
          bank_st[wr_bank]  <= B_READY;
          bank_cnt[wr_bank] <= FULL_CNT;
          bank_eof[wr_bank] <= 1'b0;
          wr_bank           <= ~wr_bank;
          wr_cnt            <= '0;
        end else begin
          bank_st[wr_bank] <= B_FILL;
          wr_cnt           <= wr_cnt + 1'b1;
        end
      end

      case (rd_st)
        RD_IDLE: begin
          if (bank_st[rd_bank] == B_READY) begin
            bank_st[rd_bank] <= B_BUSY;
            spike_valid      <= 1'b1;
            addr_most        <= bank_cnt[rd_bank];
            frame_last       <= bank_eof[rd_bank];
            rd_st            <= RD_SERVE;
          end
        end
        RD_SERVE: begin
          s_index_ram <= mem[rd_bank][addr_r_spike];
          if (conv_over) begin
            bank_st[rd_bank] <= B_FREE;
            rd_bank          <= ~rd_bank;
            spike_valid      <= 1'b0;
            addr_most        <= '0;
            frame_last       <= 1'b0;
            rd_st            <= RD_IDLE;
          end
        end
        default: rd_st <= RD_IDLE;
      endcase
    end
  end

`ifdef CONV1_BUF_STAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spike_total <= '0;
    end else if (accept_word && (spike_total != 32'hFFFF_FFFF)) begin
      spike_total <= spike_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv1_spike_pingpong_buf.sv
// Directed self-checking bench for conv1_spike_pingpong_buf (small DEPTH for short runs).
module tb_conv1_spike_pingpong_buf;

  localparam int unsigned IDX_W     = 16;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AF_MARGIN = 4;
  localparam logic [15:0] EOT       = 16'hFAF1;
  localparam logic [15:0] EOF       = 16'hF1FA;

  logic              clk;
  logic              rstn;
  logic              w_en;
  logic [IDX_W-1:0]  s_index_i;
  logic              almost_full;
  logic              full;
  logic [ADDR_W-1:0] addr_most;
  logic              spike_valid;
  logic [ADDR_W-1:0] addr_r_spike;
  logic [IDX_W-1:0]  s_index_ram;
  logic              conv_over;
  logic              frame_last;
  logic              overflow;
`ifdef CONV1_BUF_STAT_EN
  logic [31:0]       spike_total;
`endif

  int compared;
  int mismatched;

  conv1_spike_pingpong_buf #(
    .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN),
    .EOT_MARK(EOT), .EOF_MARK(EOF)
  ) dut (
    .clk(clk), .rstn(rstn), .w_en(w_en), .s_index_i(s_index_i),
    .almost_full(almost_full), .full(full), .addr_most(addr_most),
    .spike_valid(spike_valid), .addr_r_spike(addr_r_spike),
    .s_index_ram(s_index_ram), .conv_over(conv_over), .frame_last(frame_last),
`ifdef CONV1_BUF_STAT_EN
    .spike_total(spike_total),
`endif
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: inputs held across the edge, outputs settled 1ns after it.
  task automatic applyStimulus(input logic we, input logic [15:0] data, input logic co);
    w_en      = we;
    s_index_i = data;
    conv_over = co;
    @(posedge clk);
    #1;
    w_en      = 1'b0;
    conv_over = 1'b0;
  endtask

  task automatic readAt(input int addr);
    addr_r_spike = ADDR_W'(addr);
    applyStimulus(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rstn         = 1'b0;
    w_en         = 1'b0;
    s_index_i    = '0;
    addr_r_spike = '0;
    conv_over    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(spike_valid), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_afull", 32'(almost_full), 32'd0);
    checkOutput("rst_addr_most", 32'(addr_most), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_ram", 32'(s_index_ram), 32'd0);
    rstn = 1'b1;

    // 1: five words + EOT into bank0
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0);
    applyStimulus(1'b1, EOT, 1'b0);
    checkOutput("t1_valid_pre", 32'(spike_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t1_valid", 32'(spike_valid), 32'd1);
    checkOutput("t1_addr_most", 32'(addr_most), 32'd5);
    checkOutput("t1_frame_last", 32'(frame_last), 32'd0);
    for (int i = 0; i < 5; i++) begin
      readAt(i);
      checkOutput($sformatf("t1_rd%0d", i), 32'(s_index_ram), 32'h1000 + 32'(i));
    end
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t1_release", 32'(spike_valid), 32'd0);

    // 2: three words + EOF into bank1
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0);
    applyStimulus(1'b1, EOF, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t2_valid", 32'(spike_valid), 32'd1);
    checkOutput("t2_addr_most", 32'(addr_most), 32'd3);
    checkOutput("t2_frame_last", 32'(frame_last), 32'd1);
    readAt(1);
    checkOutput("t2_rd1", 32'(s_index_ram), 32'h2001);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t2_release", 32'(spike_valid), 32'd0);
    checkOutput("t2_fl_clr", 32'(frame_last), 32'd0);
    checkOutput("t2_am_clr", 32'(addr_most), 32'd0);

    // 3: both banks closed, no release -> full and overflow
    applyStimulus(1'b1, 16'h3000, 1'b0);
    applyStimulus(1'b1, 16'h3001, 1'b0);
    applyStimulus(1'b1, EOT, 1'b0);
    applyStimulus(1'b1, 16'h3100, 1'b0);
    applyStimulus(1'b1, 16'h3101, 1'b0);
    checkOutput("t3_full_pre", 32'(full), 32'd0);
    applyStimulus(1'b1, EOT, 1'b0);
    checkOutput("t3_full", 32'(full), 32'd1);
    checkOutput("t3_afull", 32'(almost_full), 32'd1);
    checkOutput("t3_ovf_pre", 32'(overflow), 32'd0);
    checkOutput("t3_addr_most", 32'(addr_most), 32'd2);
    applyStimulus(1'b1, 16'h3333, 1'b0);
    checkOutput("t3_ovf", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t3_full_drop", 32'(full), 32'd0);
    checkOutput("t3_gap", 32'(spike_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t3_b1_valid", 32'(spike_valid), 32'd1);
    checkOutput("t3_b1_am", 32'(addr_most), 32'd2);
    readAt(0);
    checkOutput("t3_b1_rd0", 32'(s_index_ram), 32'h3100);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: almost_full threshold and auto-close at DEPTH
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 16'h4000 + 16'(i), 1'b0);
    checkOutput("t4_afull_11", 32'(almost_full), 32'd0);
    applyStimulus(1'b1, 16'h400B, 1'b0);
    checkOutput("t4_afull_12", 32'(almost_full), 32'd1);
    checkOutput("t4_full_12", 32'(full), 32'd0);
    for (int i = 12; i < 16; i++) applyStimulus(1'b1, 16'h4000 + 16'(i), 1'b0);
    checkOutput("t4_afull_close", 32'(almost_full), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t4_valid", 32'(spike_valid), 32'd1);
    checkOutput("t4_addr_most", 32'(addr_most), 32'd16);
    readAt(15);
    checkOutput("t4_rd15", 32'(s_index_ram), 32'h400F);

    // 5: marker on empty bank1 ignored; close bank1 together with release of bank0
    applyStimulus(1'b1, EOT, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t5_no_toggle", 32'(full), 32'd0);
    checkOutput("t5_still_b0", 32'(addr_most), 32'd16);
    applyStimulus(1'b1, 16'h5000, 1'b0);
    applyStimulus(1'b1, 16'h5001, 1'b0);
    applyStimulus(1'b1, EOF, 1'b1);
    checkOutput("t5_gap", 32'(spike_valid), 32'd0);
    checkOutput("t5_full", 32'(full), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t5_valid", 32'(spike_valid), 32'd1);
    checkOutput("t5_addr_most", 32'(addr_most), 32'd2);
    checkOutput("t5_frame_last", 32'(frame_last), 32'd1);
    readAt(1);
    checkOutput("t5_rd1", 32'(s_index_ram), 32'h5001);

    // 6: asynchronous reset mid-serve, then a fresh stream
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_valid", 32'(spike_valid), 32'd0);
    checkOutput("t6_addr_most", 32'(addr_most), 32'd0);
    checkOutput("t6_frame_last", 32'(frame_last), 32'd0);
    checkOutput("t6_ram", 32'(s_index_ram), 32'd0);
    checkOutput("t6_ovf", 32'(overflow), 32'd0);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h6000 + 16'(i), 1'b0);
    applyStimulus(1'b1, EOT, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t6_new_valid", 32'(spike_valid), 32'd1);
    checkOutput("t6_new_am", 32'(addr_most), 32'd5);
    readAt(3);
    checkOutput("t6_new_rd3", 32'(s_index_ram), 32'h6003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
